// File: rtl/avg_frame_tx_pkg.sv
// Shared definitions for the averager frame transmitter: FSM encoding and parameter defaults.
package avg_frame_tx_pkg;

  localparam int NOF_BITS_DEF     = 32;
  localparam int DEPTH_DEF        = 16;
  localparam int RESP_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_WAIT  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/avg_frame_buf.sv
// Sample buffer: DEPTH x NOF_BITS register file, one write port, one combinational read port.
module avg_frame_buf #(
  parameter int NOF_BITS = 32,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [NOF_BITS-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [NOF_BITS-1:0] rdata_o
);

  logic [NOF_BITS-1:0] mem_q [DEPTH];

  // Storage is deliberately left unreset; only the fill count gives it meaning.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/avg_frame_tx.sv
// Frame transmitter: buffers samples, emits one framed burst to the averager, captures its result.
module avg_frame_tx
  import avg_frame_tx_pkg::*;
#(
  parameter int NOF_BITS     = NOF_BITS_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [NOF_BITS-1:0]      wr_data,
  input  logic                     send,
  output logic [$clog2(DEPTH):0]   buf_count,
  output logic                     full,
  output logic                     busy,
  output logic                     start,
  output logic                     data_first,
  output logic                     data_last,
  output logic [NOF_BITS-1:0]      data_out,
  input  logic                     avg_done,
  input  logic [NOF_BITS:0]        avg_result,
  output logic [NOF_BITS:0]        result,
  output logic                     result_valid,
  output logic                     err_empty,
  output logic                     err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  tx_state_e           state_q;
  logic [CW-1:0]       count_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [TW-1:0]       timer_q;
  logic                start_q, first_q, last_q;
  logic [NOF_BITS-1:0] dout_q;
  logic [NOF_BITS:0]   result_q;
  logic                rvalid_q, err_empty_q, err_timeout_q;

  logic                full_d;
  logic                wr_accept_d;
  logic [CW-1:0]       count_eff_d;
  logic [AW-1:0]       rd_addr_d;
  logic [NOF_BITS-1:0] rd_data;

  assign full_d      = (count_q == CW'(DEPTH));
  assign wr_accept_d = (state_q == ST_IDLE) && wr_en && !full_d;
  assign count_eff_d = count_q + CW'(wr_accept_d);
  // Beat 0 is fetched while still in START so it is registered for the first SEND cycle.
  assign rd_addr_d   = (state_q == ST_START) ? '0 : rd_ptr_q;

  avg_frame_buf #(
    .NOF_BITS (NOF_BITS),
    .DEPTH    (DEPTH),
    .AW       (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (wr_accept_d),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_addr_d),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      timer_q       <= '0;
      start_q       <= 1'b0;
      first_q       <= 1'b0;
      last_q        <= 1'b0;
      dout_q        <= '0;
      result_q      <= '0;
      rvalid_q      <= 1'b0;
      err_empty_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      rvalid_q      <= 1'b0;
      err_empty_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wr_accept_d) count_q <= count_eff_d;
          if (send) begin
            if (count_eff_d == '0) begin
              err_empty_q <= 1'b1;
            end else begin
              start_q <= 1'b1;
              state_q <= ST_START;
            end
          end
        end
        ST_START: begin
          start_q  <= 1'b0;
          dout_q   <= rd_data;
          first_q  <= 1'b1;
          last_q   <= (count_q == CW'(1));
          rd_ptr_q <= AW'(1);
          state_q  <= ST_SEND;
        end
        ST_SEND: begin
          if (last_q) begin
            dout_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            timer_q <= '0;
            state_q <= ST_WAIT;
          end else begin
            dout_q   <= rd_data;
            first_q  <= 1'b0;
            last_q   <= ({1'b0, rd_ptr_q} == count_q - CW'(1));
            rd_ptr_q <= rd_ptr_q + AW'(1);
          end
        end
        ST_WAIT: begin
          timer_q <= timer_q + TW'(1);
          // A done arriving on the timeout cycle still counts as a valid response.
          if (avg_done) begin
            result_q <= avg_result;
            rvalid_q <= 1'b1;
            count_q  <= '0;
            state_q  <= ST_IDLE;
          end else if (timer_q == TW'(RESP_TIMEOUT - 1)) begin
            err_timeout_q <= 1'b1;
            count_q       <= '0;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign buf_count    = count_q;
  assign full         = full_d;
  assign busy         = (state_q != ST_IDLE);
  assign start        = start_q;
  assign data_first   = first_q;
  assign data_last    = last_q;
  assign data_out     = dout_q;
  assign result       = result_q;
  assign result_valid = rvalid_q;
  assign err_empty    = err_empty_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_avg_frame_tx.sv
// Directed bench for avg_frame_tx with hand-computed expectations.
module tb_avg_frame_tx;

  localparam int NB = 32;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [NB-1:0] wr_data;
  logic          send;
  logic [4:0]    buf_count;
  logic          full, busy, start, data_first, data_last;
  logic [NB-1:0] data_out;
  logic          avg_done;
  logic [NB:0]   avg_result;
  logic [NB:0]   result;
  logic          result_valid, err_empty, err_timeout;

  int compared = 0;
  int mismatched = 0;

  avg_frame_tx #(.NOF_BITS(NB), .DEPTH(DP), .RESP_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .send(send),
    .buf_count(buf_count), .full(full), .busy(busy), .start(start),
    .data_first(data_first), .data_last(data_last), .data_out(data_out),
    .avg_done(avg_done), .avg_result(avg_result), .result(result),
    .result_valid(result_valid), .err_empty(err_empty), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [NB-1:0] v);
    wr_en = 1'b1;
    wr_data = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic done_with(input logic [NB:0] v);
    avg_done = 1'b1;
    avg_result = v;
    tick();
    avg_done = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; send = 1'b0;
    avg_done = 1'b0; avg_result = '0;
    tick(); tick();
    chk("rst_count", buf_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_result", result, 0);
    chk("rst_dout", data_out, 0);
    rst_n = 1'b1;
    tick();

    // four-sample frame
    wr(10); wr(20); wr(30); wr(40);
    chk("t1_count", buf_count, 4);
    send = 1'b1; tick(); send = 1'b0;
    chk("t1_start", start, 1);
    chk("t1_busy", busy, 1);
    chk("t1_first_pre", data_first, 0);
    tick();
    chk("t1_start_drop", start, 0);
    chk("t1_b0_data", data_out, 10);
    chk("t1_b0_first", data_first, 1);
    chk("t1_b0_last", data_last, 0);
    tick();
    chk("t1_b1_data", data_out, 20);
    chk("t1_b1_first", data_first, 0);
    tick();
    chk("t1_b2_data", data_out, 30);
    chk("t1_b2_last", data_last, 0);
    tick();
    chk("t1_b3_data", data_out, 40);
    chk("t1_b3_last", data_last, 1);
    tick();
    chk("t1_wait_last", data_last, 0);
    chk("t1_wait_dout", data_out, 0);
    chk("t1_wait_busy", busy, 1);
    done_with(25);
    chk("t1_result", result, 25);
    chk("t1_rvalid", result_valid, 1);
    chk("t1_count_clr", buf_count, 0);
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_rvalid_drop", result_valid, 0);
    chk("t1_result_hold", result, 25);

    // single-sample frame
    wr(7);
    send = 1'b1; tick(); send = 1'b0;
    chk("t2_start", start, 1);
    tick();
    chk("t2_data", data_out, 7);
    chk("t2_first", data_first, 1);
    chk("t2_last", data_last, 1);
    tick();
    chk("t2_wait_first", data_first, 0);
    done_with(7);
    chk("t2_result", result, 7);

    // send with empty buffer
    send = 1'b1; tick(); send = 1'b0;
    chk("t3_err_empty", err_empty, 1);
    chk("t3_no_start", start, 0);
    chk("t3_not_busy", busy, 0);
    tick();
    chk("t3_err_drop", err_empty, 0);
    chk("t3_still_idle", busy, 0);
    chk("t3_no_start2", start, 0);

    // send in the same cycle as the only write
    wr_en = 1'b1; wr_data = 99; send = 1'b1;
    tick();
    wr_en = 1'b0; send = 1'b0;
    chk("t3b_start", start, 1);
    chk("t3b_count", buf_count, 1);
    chk("t3b_no_err", err_empty, 0);
    tick();
    chk("t3b_data", data_out, 99);
    chk("t3b_last", data_last, 1);
    tick();
    done_with(99);
    chk("t3b_result", result, 99);

    // overfill, 16-beat frame, then timeout
    for (int i = 0; i < DP; i++) wr(NB'(i * 3 + 1));
    chk("t4_full", full, 1);
    chk("t4_count16", buf_count, 16);
    wr(999);
    chk("t4_drop_count", buf_count, 16);
    send = 1'b1; tick(); send = 1'b0;
    chk("t4_start", start, 1);
    for (int i = 0; i < DP; i++) begin
      tick();
      chk("t4_beat_data", data_out, 64'(i * 3 + 1));
      chk("t4_beat_first", data_first, (i == 0) ? 1 : 0);
      chk("t4_beat_last", data_last, (i == DP - 1) ? 1 : 0);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!err_timeout && n < 400);
    chk("t4_timeout_cycles", n, 256);
    chk("t4_timeout_pulse", err_timeout, 1);
    chk("t4_result_kept", result, 99);
    chk("t4_no_rvalid", result_valid, 0);
    chk("t4_idle", busy, 0);
    chk("t4_count_clr", buf_count, 0);
    tick();
    chk("t4_timeout_drop", err_timeout, 0);

    // reset during the second beat
    wr(1); wr(2); wr(3); wr(4);
    send = 1'b1; tick(); send = 1'b0;
    tick();
    chk("t5_b0", data_out, 1);
    tick();
    chk("t5_b1", data_out, 2);
    rst_n = 1'b0;
    tick();
    chk("t5_dout", data_out, 0);
    chk("t5_first", data_first, 0);
    chk("t5_last", data_last, 0);
    chk("t5_busy", busy, 0);
    chk("t5_count", buf_count, 0);
    chk("t5_result", result, 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("t5_idle", busy, 0);
    chk("t5_no_last", data_last, 0);
    chk("t5_no_start", start, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
